// File: rtl/load_store_unit_if.sv
// Core-side operation, data-bus and write-back signals of the load/store unit.
// master = core/memory side, slave = the LSU itself.
interface load_store_unit_if;
  logic        op_valid;
  logic        op_ready;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_base;
  logic [31:0] op_offset;
  logic [31:0] op_wdata;
  logic [4:0]  op_rd_addr;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  modport master (
    output op_valid, op_store, op_funct3,
    output op_base, op_offset, op_wdata,
    output op_rd_addr,
    input  op_ready,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack,
    input  wb_we, wb_rd_addr, wb_data,
    input  done, err
  );

  modport slave (
    input  op_valid, op_store, op_funct3,
    input  op_base, op_offset, op_wdata,
    input  op_rd_addr,
    output op_ready,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack,
    output wb_we, wb_rd_addr, wb_data,
    output done, err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one req/ack bus access in flight, load write-back.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W instead of forcing alignment.
module load_store_unit #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    ABORT
  } state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  localparam bit          TMO_EN   = (BUS_TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = 32'(BUS_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  acc_t        acc_q;
  acc_t        acc_d;
  logic [31:0] tmo_q;
  logic [31:0] wb_data_q;
  logic [31:0] ld_val;

  logic [31:0] ea;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        f3_ok;
  logic        misal;
  logic [1:0]  lane;
  logic        accept;
  logic        timed_out;

  assign ea     = bus.op_base + bus.op_offset;
  assign is_b   = (bus.op_funct3[1:0] == 2'b00);
  assign is_h   = (bus.op_funct3[1:0] == 2'b01);
  assign is_w   = (bus.op_funct3 == 3'b010);
  assign accept = bus.op_valid && (state_q == IDLE);

  always_comb begin
    f3_ok = 1'b0;
    unique case (bus.op_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.op_store;
      default:                f3_ok = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = (is_h && ea[0]) ||
                 (is_w && (ea[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Without trapping, H/W silently lose their low address bits.
  always_comb begin
    lane = 2'b00;
    unique case (1'b1)
      is_b:    lane = ea[1:0];
      is_h:    lane = {ea[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  always_comb begin
    acc_d        = acc_q;
    acc_d.store  = bus.op_store;
    acc_d.funct3 = bus.op_funct3;
    acc_d.lo     = lane;
    acc_d.rd     = bus.op_rd_addr;
    acc_d.addr   = {ea[31:2], 2'b00};
    acc_d.wdata  = bus.op_wdata;
    acc_d.wstrb  = 4'b1111;
    unique case (1'b1)
      is_b: begin
        acc_d.wdata = {4{bus.op_wdata[7:0]}};
        acc_d.wstrb = 4'b0001 << lane;
      end
      is_h: begin
        acc_d.wdata = {2{bus.op_wdata[15:0]}};
        acc_d.wstrb = lane[1] ? 4'b1100
                              : 4'b0011;
      end
      default: ;
    endcase
    if (!bus.op_store) acc_d.wstrb = 4'b0000;
  end

  always_comb begin
    logic [7:0]  rb;
    logic [15:0] rh;
    rb     = bus.mem_rdata[{acc_q.lo, 3'b000} +: 8];
    rh     = acc_q.lo[1] ? bus.mem_rdata[31:16]
                         : bus.mem_rdata[15:0];
    ld_val = bus.mem_rdata;
    unique case (acc_q.funct3)
      3'b000:  ld_val = {{24{rb[7]}}, rb};
      3'b001:  ld_val = {{16{rh[15]}}, rh};
      3'b100:  ld_val = {24'd0, rb};
      3'b101:  ld_val = {16'd0, rh};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  assign timed_out = TMO_EN && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (!f3_ok || misal) ? ABORT : REQ;
      end
      REQ: begin
        if (bus.mem_ack)    state_d = RESP;
        else if (timed_out) state_d = ABORT;
      end
      RESP:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      tmo_q     <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) acc_q <= acc_d;
      if (state_q == REQ) tmo_q <= tmo_q + 32'd1;
      else                tmo_q <= '0;
      if (state_q == REQ && bus.mem_ack)
        wb_data_q <= ld_val;
    end
  end

  assign bus.op_ready   = (state_q == IDLE);
  assign bus.mem_req    = (state_q == REQ);
  assign bus.mem_we     = (state_q == REQ) && acc_q.store;
  assign bus.mem_addr   = acc_q.addr;
  assign bus.mem_wdata  = acc_q.wdata;
  assign bus.mem_wstrb  = acc_q.wstrb;
  assign bus.wb_we      = (state_q == RESP) && !acc_q.store &&
                          (acc_q.rd != 5'd0);
  assign bus.wb_rd_addr = acc_q.rd;
  assign bus.wb_data    = wb_data_q;
  assign bus.done       = (state_q == RESP) || (state_q == ABORT);
  assign bus.err        = (state_q == ABORT);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against a lane/extension reference model.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.BUS_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit m_legal(bit st, logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd2: return 1'b1;
      3'd4, 3'd5:       return !st;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic int m_size(logic [2:0] f3);
    int s;
    s = int'(f3) % 4;
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  function automatic bit m_misal(logic [2:0] f3, logic [31:0] ea);
`ifdef LSU_MISALIGN_TRAP_EN
    return (ea % m_size(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_off(logic [2:0] f3, logic [31:0] ea);
    int sz;
    sz = m_size(f3);
    return ((ea % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] m_strb(bit st, logic [2:0] f3,
                                         logic [31:0] ea);
    if (!st) return 0;
    return ((1 << m_size(f3)) - 1) << m_off(f3, ea);
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3,
                                          logic [31:0] wd);
    case (m_size(f3))
      1:       return (wd % 256) * 32'h0101_0101;
      2:       return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3,
                                         logic [31:0] ea,
                                         logic [31:0] rd);
    longint v;
    longint span;
    int sz;
    sz   = m_size(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'(rd) >> (8 * m_off(f3, ea))) % span;
    if (f3 < 4 && sz < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic run_op(string tag, bit st, logic [2:0] f3,
                        logic [31:0] base, logic [31:0] off,
                        logic [31:0] wd, logic [4:0] rd,
                        int dly, logic [31:0] rdata, bit no_ack);
    logic [31:0] ea;
    bit bad, fin, exp_we;
    int req_n, k, exp_req;
    ea      = base + off;
    bad     = !m_legal(st, f3) || m_misal(f3, ea);
    exp_req = bad ? 0 : no_ack ? 4 : dly + 1;
    exp_we  = !bad && !no_ack && !st && rd != 0;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(bus.op_ready), 1);
    bus.op_valid   = 1'b1;
    bus.op_store   = st;
    bus.op_funct3  = f3;
    bus.op_base    = base;
    bus.op_offset  = off;
    bus.op_wdata   = wd;
    bus.op_rd_addr = rd;
    @(posedge clk);
    #1;
    bus.op_valid   = 1'b0;
    bus.op_base    = $urandom;
    bus.op_offset  = $urandom;
    bus.op_wdata   = $urandom;
    bus.op_funct3  = 3'($urandom);
    bus.op_rd_addr = 5'($urandom);
    req_n = 0;
    fin   = 1'b0;
    k     = 0;
    while (!fin && k < 20) begin
      @(negedge clk);
      k++;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        req_n++;
        if (req_n == 1) begin
          chk({tag, ".addr"}, bus.mem_addr, ea & ~32'd3);
          chk({tag, ".strb"}, 32'(bus.mem_wstrb),
              m_strb(st, f3, ea));
          chk({tag, ".we"}, 32'(bus.mem_we), 32'(st));
          if (st)
            chk({tag, ".wdata"}, bus.mem_wdata, m_wdata(f3, wd));
        end
        if (!no_ack && req_n == dly + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
      if (bus.done) begin
        fin = 1'b1;
        chk({tag, ".reqcyc"}, req_n, exp_req);
        chk({tag, ".lat"}, k, exp_req + 1);
        chk({tag, ".err"}, 32'(bus.err), 32'(bad || no_ack));
        chk({tag, ".wbwe"}, 32'(bus.wb_we), 32'(exp_we));
        if (exp_we) begin
          chk({tag, ".wbrd"}, 32'(bus.wb_rd_addr), 32'(rd));
          chk({tag, ".wbdata"}, bus.wb_data,
              m_load(f3, ea, rdata));
        end
      end
    end
    if (!fin) chk({tag, ".done_timeout"}, 0, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk({tag, ".idle"}, 32'(bus.op_ready), 1);
    chk({tag, ".done1"}, 32'(bus.done), 0);
  endtask

  initial begin
    bus.op_valid   = 1'b0;
    bus.op_store   = 1'b0;
    bus.op_funct3  = 3'd0;
    bus.op_base    = '0;
    bus.op_offset  = '0;
    bus.op_wdata   = '0;
    bus.op_rd_addr = '0;
    bus.mem_rdata  = '0;
    bus.mem_ack    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(bus.op_ready), 1);
    chk("rst.req", 32'(bus.mem_req), 0);
    chk("rst.we", 32'(bus.mem_we), 0);
    chk("rst.addr", bus.mem_addr, 0);
    chk("rst.wdata", bus.mem_wdata, 0);
    chk("rst.strb", 32'(bus.mem_wstrb), 0);
    chk("rst.wbwe", 32'(bus.wb_we), 0);
    chk("rst.wbrd", 32'(bus.wb_rd_addr), 0);
    chk("rst.wbdata", bus.wb_data, 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.err", 32'(bus.err), 0);
    reset_n = 1'b1;

    // Stray ack while idle must do nothing.
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("stray.done", 32'(bus.done), 0);
    chk("stray.ready", 32'(bus.op_ready), 1);

    run_op("lw", 0, 3'd2, 32'h100, 32'd4, 0, 5, 0,
           32'hDEAD_BEEF, 0);
    run_op("lb", 0, 3'd0, 32'h200, 32'd3, 0, 7, 1,
           32'h8012_3456, 0);
    run_op("lbu", 0, 3'd4, 32'h200, 32'd3, 0, 8, 0,
           32'h8012_3456, 0);
    run_op("lhu", 0, 3'd5, 32'h202, 32'd0, 0, 9, 2,
           32'hBEEF_0000, 0);
    run_op("sb", 1, 3'd0, 32'h10, 32'd1, 32'hA5, 3, 0, 0, 0);
    run_op("sh", 1, 3'd1, 32'h10, 32'd2, 32'h1234, 3, 1, 0, 0);
    run_op("sw", 1, 3'd2, 32'h40, 32'd0, 32'h0BAD_F00D, 0, 0, 0, 0);
    run_op("rd0", 0, 3'd2, 32'h80, 32'd0, 0, 0, 0, 32'h1, 0);
    run_op("wrap", 0, 3'd2, 32'hFFFF_FFFC, 32'd8, 0, 4, 0,
           32'h5, 0);
    run_op("tmo", 0, 3'd2, 32'h300, 32'd0, 0, 6, 0, 0, 1);
    run_op("ill", 0, 3'd3, 32'h300, 32'd0, 0, 6, 0, 0, 0);
    run_op("illst", 1, 3'd4, 32'h300, 32'd0, 0, 6, 0, 0, 0);
    run_op("mislw", 0, 3'd2, 32'h100, 32'd2, 0, 10, 0,
           32'hCAFE_F00D, 0);

    // Reset in the middle of a request.
    @(negedge clk);
    bus.op_valid   = 1'b1;
    bus.op_store   = 1'b0;
    bus.op_funct3  = 3'd2;
    bus.op_base    = 32'h500;
    bus.op_offset  = 32'd0;
    bus.op_rd_addr = 5'd11;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
    chk("mrst.req_before", 32'(bus.mem_req), 1);
    reset_n = 1'b0;
    #1;
    chk("mrst.req", 32'(bus.mem_req), 0);
    chk("mrst.wbwe", 32'(bus.wb_we), 0);
    chk("mrst.done", 32'(bus.done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst.ready", 32'(bus.op_ready), 1);
    chk("mrst.wbwe2", 32'(bus.wb_we), 0);

    for (int i = 0; i < 300; i++) begin
      bit st;
      logic [31:0] base;
      st   = 1'($urandom);
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                         : $urandom;
      run_op("rnd", st, 3'($urandom), base,
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7))
                                         : $urandom,
             $urandom, 5'($urandom), $urandom_range(0, 2),
             $urandom, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
